// File: rtl/pe_linear_mac_stream.sv
// Streaming fully-connected layer PE: buffers one input vector, then emits requantized groups of output features.
// Optional perf counters are built when PE_LINEAR_MAC_PERF_CNT_EN is defined; otherwise perf_* are tied to 0.
module pe_linear_mac_stream #(
  parameter int pDATA_WIDTH      = 8,
  parameter int pCHANNEL         = 4,
  parameter int pOUTPUT_PARALLEL = 2,
  parameter int pACC_WIDTH       = 32,
  parameter int pMAX_IN_BEATS    = 64,
  parameter int pMAX_OUT_GROUPS  = 8,
  localparam int IB_W   = $clog2(pMAX_IN_BEATS + 1),
  localparam int OG_W   = $clog2(pMAX_OUT_GROUPS + 1),
  localparam int LANE_W = (pOUTPUT_PARALLEL > 1) ? $clog2(pOUTPUT_PARALLEL) : 1,
  localparam int WA_W   = $clog2(pMAX_IN_BEATS * pMAX_OUT_GROUPS),
  localparam int BA_W   = $clog2(pMAX_OUT_GROUPS * pOUTPUT_PARALLEL),
  localparam int VEC_W  = pCHANNEL * pDATA_WIDTH,
  localparam int OUT_W  = pOUTPUT_PARALLEL * pDATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IB_W-1:0]       cfg_in_beats,
  input  logic [OG_W-1:0]       cfg_out_groups,
  input  logic [4:0]            cfg_shift,
  input  logic                  cfg_relu,
  input  logic                  weight_we,
  input  logic [LANE_W-1:0]     weight_lane,
  input  logic [WA_W-1:0]       weight_addr,
  input  logic [VEC_W-1:0]      weight_data,
  input  logic                  bias_we,
  input  logic [BA_W-1:0]       bias_addr,
  input  logic [pACC_WIDTH-1:0] bias_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VEC_W-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [31:0]           perf_busy,
  output logic [31:0]           perf_stall
);
  localparam int DW     = pDATA_WIDTH;
  localparam int ACC    = pACC_WIDTH;
  localparam int P      = pOUTPUT_PARALLEL;
  localparam int BUF_AW = (pMAX_IN_BEATS > 1) ? $clog2(pMAX_IN_BEATS) : 1;
  localparam int G_AW   = (pMAX_OUT_GROUPS > 1) ? $clog2(pMAX_OUT_GROUPS) : 1;
  localparam logic signed [ACC-1:0] SAT_HI = ACC'(2 ** (DW - 1) - 1);
  localparam logic signed [ACC-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_POST, S_EMIT} state_t;

  state_t                 state;
  logic [IB_W-1:0]        ib_q, beat_cnt, step, ib_clamped;
  logic [OG_W-1:0]        og_q, grp, og_clamped;
  logic [4:0]             shift_q;
  logic                   relu_q;
  logic [WA_W-1:0]        w_addr;
  logic signed [ACC-1:0]  acc      [P];
  logic signed [ACC-1:0]  lane_sum [P];
  logic [OUT_W-1:0]       post_data;

  logic [VEC_W-1:0]       buf_mem  [pMAX_IN_BEATS];
  logic [VEC_W-1:0]       wmem     [P][pMAX_IN_BEATS*pMAX_OUT_GROUPS];
  logic signed [ACC-1:0]  bmem     [P][pMAX_OUT_GROUPS];
  logic [VEC_W-1:0]       buf_q;
  logic [VEC_W-1:0]       w_q      [P];
  logic signed [ACC-1:0]  bias_q   [P];

  logic                   accept, mem_we_ok;
  logic [BUF_AW-1:0]      buf_waddr;

  assign accept    = in_valid & in_ready;
  assign mem_we_ok = (state == S_IDLE) & ~accept;
  assign buf_waddr = (state == S_LOAD) ? beat_cnt[BUF_AW-1:0] : '0;

  assign ib_clamped = (cfg_in_beats == '0) ? IB_W'(1) :
                      (cfg_in_beats > IB_W'(pMAX_IN_BEATS)) ? IB_W'(pMAX_IN_BEATS) : cfg_in_beats;
  assign og_clamped = (cfg_out_groups == '0) ? OG_W'(1) :
                      (cfg_out_groups > OG_W'(pMAX_OUT_GROUPS)) ? OG_W'(pMAX_OUT_GROUPS) : cfg_out_groups;

  function automatic logic signed [2*DW-1:0] mul(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    return a * b;
  endfunction

  // Round half up, shift, optional ReLU, then clamp into the signed output range.
  function automatic logic [DW-1:0] requant(input logic signed [ACC-1:0] a,
                                            input logic [4:0] sh, input logic relu);
    logic signed [ACC-1:0] r;
    r = a + ((sh == 5'd0) ? '0 : (ACC'(1) << (sh - 5'd1)));
    r = r >>> sh;
    if (relu && r < 0) r = '0;
    if (r > SAT_HI)      return SAT_HI[DW-1:0];
    else if (r < SAT_LO) return SAT_LO[DW-1:0];
    else                 return r[DW-1:0];
  endfunction

  // NOTE: every always_comb output is assigned before any conditional use, so no latch is inferred.
  always_comb begin
    post_data = '0;
    for (int p = 0; p < P; p++) begin
      lane_sum[p] = '0;
      for (int c = 0; c < pCHANNEL; c++)
        lane_sum[p] = lane_sum[p] + ACC'(mul(buf_q[c*DW +: DW], w_q[p][c*DW +: DW]));
      post_data[p*DW +: DW] = requant(acc[p], shift_q, relu_q);
    end
  end

  // NOTE: memories and their read registers have no reset; their contents are undefined until written.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[buf_waddr] <= in_data;
    else        buf_q <= buf_mem[step[BUF_AW-1:0]];
  end

  // Bias address = group*P + lane, with P a power of two.
  always_ff @(posedge clk) begin
    for (int p = 0; p < P; p++) begin
      if (weight_we && mem_we_ok && weight_lane == LANE_W'(p))
        wmem[p][weight_addr] <= weight_data;
      else
        w_q[p] <= wmem[p][w_addr];
      if (bias_we && mem_we_ok && bias_addr[LANE_W-1:0] == LANE_W'(p))
        bmem[p][bias_addr[BA_W-1:LANE_W]] <= bias_data;
      else
        bias_q[p] <= bmem[p][grp[G_AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ib_q      <= '0;
      og_q      <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      beat_cnt  <= '0;
      step      <= '0;
      grp       <= '0;
      w_addr    <= '0;
      for (int p = 0; p < P; p++) acc[p] <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          ib_q    <= ib_clamped;
          og_q    <= og_clamped;
          shift_q <= cfg_shift;
          relu_q  <= cfg_relu;
          busy    <= 1'b1;
          grp     <= '0;
          step    <= '0;
          w_addr  <= '0;
          beat_cnt <= IB_W'(1);
          if (ib_clamped == IB_W'(1)) begin
            state    <= S_COMPUTE;
            in_ready <= 1'b0;
          end else begin
            state <= S_LOAD;
          end
        end
        S_LOAD: if (accept) begin
          beat_cnt <= beat_cnt + IB_W'(1);
          if (beat_cnt == ib_q - IB_W'(1)) begin
            state    <= S_COMPUTE;
            in_ready <= 1'b0;
          end
        end
        // Step k issues reads for beat k; the data lands at k+1, so the group spans IB+1 steps.
        S_COMPUTE: begin
          if (step < ib_q) w_addr <= w_addr + WA_W'(1);
          for (int p = 0; p < P; p++) begin
            if (step == IB_W'(1))  acc[p] <= bias_q[p] + lane_sum[p];
            else if (step != '0)   acc[p] <= acc[p] + lane_sum[p];
          end
          if (step == ib_q) begin
            step  <= '0;
            state <= S_POST;
          end else begin
            step <= step + IB_W'(1);
          end
        end
        S_POST: begin
          out_data  <= post_data;
          out_valid <= 1'b1;
          out_last  <= (grp == og_q - OG_W'(1));
          state     <= S_EMIT;
        end
        S_EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (out_last) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            grp   <= grp + OG_W'(1);
            state <= S_COMPUTE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PE_LINEAR_MAC_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (busy && perf_busy != '1)                    perf_busy  <= perf_busy + 32'd1;
      if (out_valid && !out_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_busy  = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: doc/pe_linear_mac_stream.md
Name: pe_linear_mac_stream

Overview:
Next-generation fully-connected (linear) layer processing element with a valid/ready streaming datapath.
- Fed one input vector at a time, pCHANNEL int8 elements per beat.
- Buffers the vector, then computes pOUTPUT_PARALLEL output features per group against on-chip weight/bias memories.
- Emits requantized int outputs group by group.
- In/out feature counts, requant shift and ReLU are runtime-configurable per vector, so one instance serves several layers.

Parameters:
pDATA_WIDTH, 8, signed activation/weight width
pCHANNEL, 4, input elements per beat (multipliers per lane)
pOUTPUT_PARALLEL, 2, output lanes per group
pACC_WIDTH, 32, signed accumulator and bias width
pMAX_IN_BEATS, 64, max input beats per vector (in_feature = beats*pCHANNEL)
pMAX_OUT_GROUPS, 8, max output groups per vector

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_in_beats  in  $clog2(pMAX_IN_BEATS+1)  input beats per vector
cfg_out_groups  in  $clog2(pMAX_OUT_GROUPS+1)  output groups per vector
cfg_shift  in  5  arithmetic right shift for requant
cfg_relu  in  1  1 = ReLU before saturation
weight_we  in  1  weight write strobe
weight_lane  in  $clog2(pOUTPUT_PARALLEL)  target lane
weight_addr  in  $clog2(pMAX_IN_BEATS*pMAX_OUT_GROUPS)  word address = group*cfg_in_beats+beat
weight_data  in  pCHANNEL*pDATA_WIDTH  pCHANNEL signed weights, element 0 in LSBs
bias_we  in  1  bias write strobe
bias_addr  in  $clog2(pMAX_OUT_GROUPS*pOUTPUT_PARALLEL)  output feature index
bias_data  in  pACC_WIDTH  signed bias
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready
in_data  in  pCHANNEL*pDATA_WIDTH  signed input elements
out_valid  out  1  output group valid
out_ready  in  1  downstream accept
out_data  out  pOUTPUT_PARALLEL*pDATA_WIDTH  lane 0 in LSBs
out_last  out  1  high with final group of a vector
busy  out  1  not IDLE

Behaviour:
- Reset values:
  - State is IDLE.
  - in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, busy = 0.
  - Accumulators and counters are cleared.
  - Memory contents are undefined.
- Config latch:
  - cfg_* are captured on the first accepted beat of a vector.
  - A value of 0 is treated as 1; values above the maximum clamp to the maximum.
  - Mid-vector cfg changes are ignored.
- Weight/bias writes:
  - Honoured only in IDLE with no beat being accepted the same cycle; ignored otherwise.
  - Memories are single-port with synchronous read, 1-cycle read latency.
- States:
  - IDLE -> LOAD on the first accepted beat.
  - LOAD: beats stored to the input buffer at index 0..IB-1; in_ready = 1. After beat IB-1 is accepted -> COMPUTE; in_ready = 0 from the next cycle until return to IDLE.
  - COMPUTE (group g): cycle k=0..IB-1 issues buffer/weight address g*IB+k. Data is returned at k+1; acc[p] += sum of pCHANNEL products, registered at the end of k+1. Accumulators start at bias[g*P+p].
  - POST: 1 cycle. Performs r = acc >>> cfg_shift with round-half-up (adds 1<<(shift-1) when shift>0). Then ReLU if enabled, then saturate to [-2^(W-1), 2^(W-1)-1]. The result is registered into out_data.
  - EMIT: out_valid = 1; out_last = (g == OG-1).
    - On out_ready: if last -> IDLE, else g+1 -> COMPUTE.
    - out_data and out_valid stay stable while out_ready = 0.
- Latency: out_valid rises IB+2 cycles after COMPUTE entry, where COMPUTE is entered the cycle after the last beat is accepted. Each subsequent group takes IB+2 cycles after the prior handshake.
- Arithmetic: products are full width; sums are sign-extended to pACC_WIDTH; overflow wraps.
- Reset mid-operation: immediate return to reset values; any partial vector is discarded.

Optional Feature:
PE_LINEAR_MAC_PERF_CNT_EN:
- When defined, adds outputs perf_busy [31:0] (counts cycles busy = 1) and perf_stall [31:0] (counts cycles out_valid & !out_ready).
- Both counters saturate at 2^32-1 and are cleared only by rst.
- When undefined, both ports exist and are tied to 0, and no counter logic is built.

Test Plan:
Common setup: pCHANNEL=4, P=2, W=8, and IB=2, OG=2 unless a line states otherwise.
- Identity sum: all weights 1, bias 0, shift 0, inputs 1..8 -> both groups emit lanes 36,36; out_last only on group 1; first out_valid 4 cycles after COMPUTE entry.
- Bias/rounding: zero inputs, bias lane0=5, lane1=-5, shift 1 -> outputs 3 and -2; with cfg_relu=1 -> 3 and 0.
- Saturation: IB=4, all inputs and weights 127 -> 127; weights -128 -> -128.
- Backpressure: hold out_ready=0 for 5 cycles at group 0 -> out_data stable, no group 1 issued, in_ready stays 0; release -> group 1 follows IB+2 cycles later.
- Writes gated: weight_we asserted during COMPUTE -> memory unchanged, next vector uses old weights.
- Reset mid-COMPUTE: assert rst -> out_valid=0, in_ready=1 next cycle; a fresh vector then produces correct results.
